// File: rtl/pc_sequencer_if.sv
// Instruction-memory handshake and JAL link-write bundle between the PC sequencer
// and the rest of the core.
interface pc_sequencer_if;
    logic        imem_req;
    logic        imem_ack;
    logic        link_we;
    logic [31:0] link_data;

    modport master (output imem_req, output link_we, output link_data, input imem_ack);
    modport slave  (input imem_req, input link_we, input link_data, output imem_ack);
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle PC controller: FETCH -> DECODE -> EXEC -> UPDATE, with next-PC selection,
// JAL link write, retired-instruction counting and a sticky halt.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter logic [3:0]  HALT_INDEX = 4'd15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            path_index,
    input  logic [25:0]           instr_addr,
    input  logic [15:0]           branch_off,
    input  logic                  branch_taken,
    input  logic [31:0]           reg_addr,
    output logic [31:0]           pc,
    output logic [2:0]            state,
    output logic                  halted,
    output logic [31:0]           retired,
    pc_sequencer_if.master        bus
);
    // imem handshake: imem_req is high exactly while in FETCH; a word is accepted on
    // any rising edge where imem_req and imem_ack are both high.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] P_J   = 4'd5;
    localparam logic [3:0] P_JAL = 4'd6;
    localparam logic [3:0] P_BR  = 4'd7;
    localparam logic [3:0] P_JR  = 4'd8;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [31:0] link_data_q, link_data_d;
    logic        jal_q, jal_d;
    logic [31:0] retired_q, retired_d;
    logic        imem_req_c, link_we_c, halted_c;
    logic [31:0] pc_seq;

    assign pc_seq = pc_q + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            next_pc_q   <= RESET_PC;
            link_data_q <= 32'd0;
            jal_q       <= 1'b0;
            retired_q   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            next_pc_q   <= next_pc_d;
            link_data_q <= link_data_d;
            jal_q       <= jal_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        link_data_d = link_data_q;
        jal_d       = jal_q;
        retired_d   = retired_q;
        imem_req_c  = 1'b0;
        link_we_c   = 1'b0;
        halted_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (path_index == HALT_INDEX) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                jal_d = (path_index == P_JAL);
                case (path_index)
                    P_J, P_JAL: next_pc_d = {pc_q[31:26], instr_addr};
                    P_BR:       next_pc_d = branch_taken
                                          ? pc_seq + {{16{branch_off[15]}}, branch_off}
                                          : pc_seq;
                    P_JR:       next_pc_d = reg_addr;
                    default:    next_pc_d = pc_seq;
                endcase
                if (path_index == P_JAL) link_data_d = pc_seq;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                pc_d      = next_pc_q;
                retired_d = retired_q + 32'd1;
                link_we_c = jal_q;
                state_d   = start ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc            = pc_q;
    assign state         = state_q;
    assign halted        = halted_c;
    assign retired       = retired_q;
    assign bus.imem_req  = imem_req_c;
    assign bus.link_we   = link_we_c;
    assign bus.link_data = link_data_q;
endmodule
